mult_shift_add_datapath: RTL and testbench

Datapath stage of the sequential unsigned shift-add multiplier. It sits directly downstream of the multiplier step controller and consumes that controller's per-cycle "counting" strobe as step_en. It accepts an operand pair over a valid/ready handshake and performs one add-and-shift per enabled step. After WIDTH steps it presents the 2*WIDTH-bit product over a valid/ready handshake.

---
 rtl/mult_pkg.sv | 6 +
 rtl/mult_add_shift_step.sv | 18 +
 rtl/mult_shift_add_datapath.sv | 78 +++++++
 tb/tb_mult_shift_add_datapath.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared constants and state encoding for the shift-add multiplier datapath
package mult_pkg;
    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = $clog2(WIDTH_DEF + 1);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
endpackage

// File: rtl/mult_add_shift_step.sv
// mult_add_shift_step: one combinational add-and-shift step of an unsigned shift-add multiply
//   prod_i  : current {accumulator, remaining multiplier bits}
//   mcand   : multiplicand
//   prod_o  : next product value
module mult_add_shift_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] prod_i,
    input  logic [WIDTH-1:0]   mcand,
    output logic [2*WIDTH-1:0] prod_o
);
    logic [WIDTH:0] sum;
    always_comb begin
        sum    = {1'b0, prod_i[2*WIDTH-1:WIDTH]} + (prod_i[0] ? {1'b0, mcand} : '0);
        // the carry lands in the MSB as the whole product shifts right by one
        prod_o = {sum, prod_i[WIDTH-1:1]};
    end
endmodule

// File: rtl/mult_shift_add_datapath.sv
// mult_shift_add_datapath: sequential unsigned shift-add multiplier datapath with valid/ready in and out
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready        : operand handshake (multiplicand, multiplier)
//   step_en                  : perform one add-shift step while running
//   busy, steps_done         : run status and completed step count
//   out_valid/out_ready      : product handshake, product held stable while out_valid
module mult_shift_add_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic               step_en,
    output logic               busy,
    output logic [CNT_W-1:0]   steps_done,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);
    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   product_q, product_d, step_prod;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [CNT_W-1:0]     steps_q, steps_d;

    mult_add_shift_step #(.WIDTH(WIDTH)) u_step (
        .prod_i (product_q),
        .mcand  (mcand_q),
        .prod_o (step_prod)
    );

    always_comb begin
        state_d   = state_q;
        product_d = product_q;
        mcand_d   = mcand_q;
        steps_d   = steps_q;
        case (state_q)
            IDLE: if (in_valid) begin
                mcand_d   = multiplicand;
                product_d = {{WIDTH{1'b0}}, multiplier};
                steps_d   = '0;
                state_d   = RUN;
            end
            RUN: if (step_en) begin
                product_d = step_prod;
                steps_d   = steps_q + CNT_W'(1);
                state_d   = (steps_q == CNT_W'(WIDTH - 1)) ? HOLD : RUN;
            end
            HOLD: state_d = out_ready ? IDLE : HOLD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            product_q <= '0;
            mcand_q   <= '0;
            steps_q   <= '0;
        end else begin
            state_q   <= state_d;
            product_q <= product_d;
            mcand_q   <= mcand_d;
            steps_q   <= steps_d;
        end
    end

    assign in_ready   = (state_q == IDLE) && !rst;
    assign busy       = (state_q == RUN);
    assign out_valid  = (state_q == HOLD);
    assign steps_done = steps_q;
    assign product    = product_q;
endmodule

// File: tb/tb_mult_shift_add_datapath.sv
// tb_mult_shift_add_datapath: scoreboard bench with directed, hand-computed multiply vectors
module tb_mult_shift_add_datapath;
    logic        clk = 0;
    logic        rst = 1;
    logic        in_valid = 0;
    logic        in_ready;
    logic [31:0] multiplicand = 0;
    logic [31:0] multiplier = 0;
    logic        step_en = 0;
    logic        busy;
    logic [5:0]  steps_done;
    logic        out_valid;
    logic        out_ready = 0;
    logic [63:0] product;

    logic [63:0] exp_q[$];
    int          total = 0;
    int          passed = 0;

    mult_shift_add_datapath dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .step_en      (step_en),
        .busy         (busy),
        .steps_done   (steps_done),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", product, 64'hx);
            end else begin
                check("product", product, exp_q.pop_front());
                check("steps_done_hold", 64'(steps_done), 64'd32);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                          input bit toggle, input int exp_lat);
        int lat;
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        in_valid     = 1;
        multiplicand = a;
        multiplier   = b;
        step_en      = !toggle;
        tick();
        in_valid = 0;
        exp_q.push_back(exp);
        check("in_ready_after_accept", 64'(in_ready), 64'd0);
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            step_en = toggle ? (k % 2 == 0) : 1'b1;
            if (!busy) check("busy_while_running", 64'(busy), 64'd1);
            tick();
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check("latency", 64'(lat), 64'(exp_lat));
    endtask

    task automatic take();
        out_ready = 1;
        tick();
        out_ready = 0;
        check("out_valid_after_take", 64'(out_valid), 64'd0);
        check("in_ready_after_take", 64'(in_ready), 64'd1);
    endtask

    initial begin
        rst = 1;
        tick();
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_product", product, 64'd0);
        check("rst_steps", 64'(steps_done), 64'd0);
        rst = 0;
        tick();
        check("in_ready_after_rst", 64'(in_ready), 64'd1);

        run_op(32'd3, 32'd5, 64'h0000_0000_0000_000F, 0, 32);
        take();
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, 32);
        take();
        run_op(32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080, 1, 64);

        for (int i = 0; i < 10; i++) begin
            step_en      = 1'($urandom_range(0, 1));
            in_valid     = 1'($urandom_range(0, 1));
            multiplicand = $urandom;
            multiplier   = $urandom;
            tick();
            check("hold_product", product, 64'h0B00_EA4E_242D_2080);
            check("hold_out_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1;
        take();
        in_valid = 0;
        check("no_accept_on_take", 64'(busy), 64'd0);
        check("product_kept_idle", product, 64'h0B00_EA4E_242D_2080);
        run_op(32'd6, 32'd7, 64'd42, 0, 32);
        take();

        in_valid     = 1;
        multiplicand = 32'd7;
        multiplier   = 32'd9;
        step_en      = 1;
        tick();
        in_valid = 0;
        for (int k = 0; k < 17; k++) tick();
        check("steps_before_abort", 64'(steps_done), 64'd17);
        rst = 1;
        tick();
        check("abort_product", product, 64'd0);
        check("abort_steps", 64'(steps_done), 64'd0);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd0);
        rst = 0;
        tick();
        run_op(32'd7, 32'd9, 64'd63, 0, 32);
        take();

        run_op(32'd0, 32'hDEAD_BEEF, 64'd0, 0, 32);
        take();
        run_op(32'd1, 32'hDEAD_BEEF, 64'h0000_0000_DEAD_BEEF, 0, 32);
        take();

        tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
